// File: rtl/servo_capture_if.sv
// servo_capture_if: 8-bit SoC I/O bus bundle for the servo capture block.
//   din      write data          (master -> slave)
//   address  register address    (master -> slave)
//   w_en     write strobe        (master -> slave)
//   r_en     read strobe         (master -> slave)
//   dout     registered read data (slave -> master)
interface servo_capture_if;
   logic [7:0] din;
   logic [7:0] address;
   logic       w_en;
   logic       r_en;
   logic [7:0] dout;
   modport master (output din, address, w_en, r_en, input dout);
   modport slave (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/servo_capture.sv
// servo_capture: decodes an RC-servo PWM pulse width into an 8-bit position, polled over the I/O bus.
//   clk         16 MHz system clock
//   rst_n       asynchronous active-low reset
//   bus         slave side of the I/O bus (VALUE at BASE, STATUS at BASE+1, CTRL at BASE+2)
//   servo_in    asynchronous PWM input pin
//   new_sample  one-clk strobe when VALUE is updated
module servo_capture #(
   parameter logic [7:0] BASE_ADDRESS  = 8'h00,
   parameter int         PRESCALE_MAX  = 102,
   parameter int         MIN_TICKS     = 91,
   parameter int         GUARD_TICKS   = 16,
   parameter int         TIMEOUT_TICKS = 3937
) (
   input  logic            clk,
   input  logic            rst_n,
   servo_capture_if.slave  bus,
   input  logic            servo_in,
   output logic            new_sample
);
   localparam int PW = $clog2(PRESCALE_MAX + 1);
   localparam logic [PW-1:0] P_MAX = PW'(PRESCALE_MAX);
   localparam logic [11:0] W_MIN = 12'(MIN_TICKS);
   localparam logic [11:0] W_TOP = 12'(MIN_TICKS + 255);
   localparam logic [11:0] W_LO = 12'(MIN_TICKS - GUARD_TICKS);
   localparam logic [11:0] W_HI = 12'(MIN_TICKS + 255 + GUARD_TICKS);
   localparam logic [11:0] T_MAX = 12'(TIMEOUT_TICKS);
   localparam logic [7:0] A_VAL = BASE_ADDRESS;
   localparam logic [7:0] A_ST = BASE_ADDRESS + 8'd1;
   localparam logic [7:0] A_CTRL = BASE_ADDRESS + 8'd2;

   typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE} state_t;

   state_t        state_q, state_d;
   logic [2:0]    sync_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [11:0]   width_q, width_d;
   logic [11:0]   frame_q, frame_d;
   logic [11:0]   evw_q, evw_d;
   logic          eval_q, eval_d;
   logic [7:0]    value_q, value_d;
   logic          new_q, new_d;
   logic          present_q, present_d;
   logic          rerr_q, rerr_d;
   logic          tout_q, tout_d;
   logic          en_q, en_d;
   logic [7:0]    dout_q, dout_d;
   logic          ns_q;

   logic        rise, fall, tick, to_evt, en_eff;
   logic        rd_value, wr_status, wr_ctrl;
   logic        ok, set_new, set_err;
   logic [11:0] w_inc;
   logic [7:0]  val, status;
   logic        unused_din;

   // sync_q[1] is the synchronized pin; sync_q[2] is the edge-detect history flop
   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];
   assign tick = presc_q == P_MAX;
   assign w_inc = (tick && width_q != 12'hFFF) ? width_q + 12'd1 : width_q;
   assign rd_value = bus.r_en && bus.address == A_VAL;
   assign wr_status = bus.w_en && bus.address == A_ST;
   assign wr_ctrl = bus.w_en && bus.address == A_CTRL;
   // a disabling CTRL write coinciding with the falling edge discards that sample
   assign en_eff = en_q && !(wr_ctrl && !bus.din[0]);
   // fires once, on the tick that brings the frame counter up to its limit
   assign to_evt = en_q && tick && !rise && frame_q == T_MAX - 12'd1;
   assign unused_din = ^{bus.din[7:4], bus.din[1]};

   always_comb begin
      state_d = state_q;
      presc_d = (rise || tick) ? '0 : presc_q + PW'(1);
      frame_d = rise ? '0 : (tick && frame_q != T_MAX) ? frame_q + 12'd1 : frame_q;
      width_d = width_q;
      eval_d = 1'b0;
      evw_d = evw_q;
      case (state_q)
         WAIT_LOW: if (!sync_q[1]) state_d = WAIT_RISE;
         WAIT_RISE: if (rise) begin
            width_d = '0;
            state_d = MEASURE;
         end
         MEASURE: begin
            width_d = w_inc;
            // the tick landing on the falling-edge cycle still counts, giving floor(high/period)
            if (fall) begin
               eval_d = en_eff;
               evw_d = w_inc;
               state_d = WAIT_RISE;
            end
         end
         default: state_d = WAIT_LOW;
      endcase
      if (to_evt) state_d = WAIT_LOW;
      if (!en_q) begin
         state_d = WAIT_LOW;
         presc_d = '0;
         frame_d = '0;
         width_d = '0;
         eval_d = 1'b0;
      end
   end

   always_comb begin
      ok = evw_q >= W_LO && evw_q <= W_HI;
      set_new = eval_q && ok;
      set_err = eval_q && !ok;
      val = evw_q < W_MIN ? 8'h00 : evw_q > W_TOP ? 8'hFF : 8'(evw_q - W_MIN);
      value_d = set_new ? val : value_q;
      new_d = set_new || (new_q && !rd_value);
      present_d = set_new || (present_q && !to_evt);
      rerr_d = set_err || (rerr_q && !(wr_status && bus.din[2]));
      tout_d = to_evt || (tout_q && !(wr_status && bus.din[3]));
      en_d = wr_ctrl ? bus.din[0] : en_q;
      status = {4'b0, tout_q, rerr_q, present_q, new_q};
      dout_d = !bus.r_en ? dout_q :
               bus.address == A_VAL ? value_q :
               bus.address == A_ST ? status :
               bus.address == A_CTRL ? {7'b0, en_q} : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_LOW;
         sync_q <= '0;
         presc_q <= '0;
         width_q <= '0;
         frame_q <= '0;
         evw_q <= '0;
         eval_q <= 1'b0;
         value_q <= '0;
         new_q <= 1'b0;
         present_q <= 1'b0;
         rerr_q <= 1'b0;
         tout_q <= 1'b0;
         en_q <= 1'b0;
         dout_q <= '0;
         ns_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q <= {sync_q[1:0], servo_in};
         presc_q <= presc_d;
         width_q <= width_d;
         frame_q <= frame_d;
         evw_q <= evw_d;
         eval_q <= eval_d;
         value_q <= value_d;
         new_q <= new_d;
         present_q <= present_d;
         rerr_q <= rerr_d;
         tout_q <= tout_d;
         en_q <= en_d;
         dout_q <= dout_d;
         ns_q <= set_new;
      end
   end

   assign bus.dout = dout_q;
   assign new_sample = ns_q;
endmodule
